// File: rtl/fft_peak_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fft_peak_scan_pkg
// Description : Shared definitions for the FFT peak scanner and its
//               magnitude helper: magnitude-mode encodings and FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package fft_peak_scan_pkg;

  // Magnitude mode encodings (value of the 'mode' input)
  localparam logic MAG_POW = 1'b0;  // re^2 + im^2
  localparam logic MAG_L1  = 1'b1;  // |re| + |im|

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/fft_mag_calc.sv
`default_nettype none
// ============================================================================
// Module      : fft_mag_calc
// Description : Combinational magnitude of one complex sample, exact width.
//               mode_i = MAG_POW : re*re + im*im
//               mode_i = MAG_L1  : |re| + |im|, zero-extended
// Ports       : re_i, im_i  signed DW-bit components
//               mode_i      magnitude mode select
//               mag_o       unsigned MW-bit magnitude
// Revision    : 1.0 - initial release
// ============================================================================
module fft_mag_calc
  import fft_peak_scan_pkg::*;
#(
  parameter int DW = 16,
  parameter int MW = 2*DW+1
) (
  input  logic signed [DW-1:0] re_i,
  input  logic signed [DW-1:0] im_i,
  input  logic                 mode_i,
  output logic [MW-1:0]        mag_o
);

  // Sign-extend to full product width so the multiply is exact.
  logic signed [2*DW-1:0] w_re_se;
  logic signed [2*DW-1:0] w_im_se;
  logic [2*DW-1:0]        w_re_sq;
  logic [2*DW-1:0]        w_im_sq;
  logic [MW-1:0]          w_pow;

  // One extra bit so |-2^(DW-1)| is representable.
  logic [DW:0] w_re_x;
  logic [DW:0] w_im_x;
  logic [DW:0] w_re_abs;
  logic [DW:0] w_im_abs;
  logic [DW:0] w_l1;

  assign w_re_se = {{DW{re_i[DW-1]}}, re_i};
  assign w_im_se = {{DW{im_i[DW-1]}}, im_i};
  assign w_re_sq = w_re_se * w_re_se;
  assign w_im_sq = w_im_se * w_im_se;
  // Each square is at most 2^(2*DW-2), so the MSB of each product is zero
  // and the unsigned sum fits in MW bits without overflow.
  assign w_pow   = {1'b0, w_re_sq} + {1'b0, w_im_sq};

  assign w_re_x   = {re_i[DW-1], re_i};
  assign w_im_x   = {im_i[DW-1], im_i};
  assign w_re_abs = re_i[DW-1] ? (~w_re_x + (DW+1)'(1)) : w_re_x;
  assign w_im_abs = im_i[DW-1] ? (~w_im_x + (DW+1)'(1)) : w_im_x;
  // Each term is at most 2^(DW-1), so the sum fits in DW+1 bits.
  assign w_l1     = w_re_abs + w_im_abs;

  assign mag_o = (mode_i == MAG_L1) ? {{(MW-DW-1){1'b0}}, w_l1} : w_pow;

endmodule
`default_nettype wire

// File: rtl/fft_peak_scan.sv
`default_nettype none
// ============================================================================
// Module      : fft_peak_scan
// Description : Captures one frame of N_BINS complex FFT bins, scans one bin
//               per clock and reports the strongest bin and its magnitude.
// Ports       : clk, rst (async active-low)
//               fft_valid/in_ready  frame handshake, fft_data packed bins
//               mode, skip_dc, thresh  per-frame settings, sampled at capture
//               done       one-cycle result strobe
//               freq, peak_mag, peak_valid  held results
//               frame_drop one-cycle pulse on a refused frame
// Revision    : 1.0 - initial release
// ============================================================================
module fft_peak_scan
  import fft_peak_scan_pkg::*;
#(
  parameter int N_BINS = 16,
  parameter int DW     = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fft_valid,
  output logic                       in_ready,
  input  logic [N_BINS*2*DW-1:0]     fft_data,
  input  logic                       mode,
  input  logic                       skip_dc,
  input  logic [2*DW:0]              thresh,
  output logic                       done,
  output logic [$clog2(N_BINS)-1:0]  freq,
  output logic [2*DW:0]              peak_mag,
  output logic                       peak_valid,
  output logic                       frame_drop
);

  localparam int IDX_W = $clog2(N_BINS);
  localparam int MW    = 2*DW+1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BINS-1);

  state_e state_q, state_d;

  logic [N_BINS*2*DW-1:0] buf_q;
  logic                   mode_q;
  logic                   skip_q;
  logic [MW-1:0]          thresh_q;
  logic [IDX_W-1:0]       idx_q;
  logic [MW-1:0]          best_mag_q;
  logic [IDX_W-1:0]       best_idx_q;
  logic [IDX_W-1:0]       freq_q;
  logic [MW-1:0]          peak_mag_q;
  logic                   peak_valid_q;

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (fft_valid) state_d = SCAN;
      end
      SCAN: begin
        if (idx_q == LAST_IDX) state_d = DONE;
      end
      DONE: begin
        in_ready = 1'b1;
        done     = 1'b1;
        state_d  = fft_valid ? SCAN : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  logic              w_capture;
  logic              w_scan;
  logic [2*DW-1:0]   w_bins [N_BINS];
  logic [2*DW-1:0]   w_bin;
  logic [MW-1:0]     w_mag;
  logic              w_better;
  logic [MW-1:0]     w_best_mag_nxt;
  logic [IDX_W-1:0]  w_best_idx_nxt;

  assign w_capture  = fft_valid & in_ready;
  assign w_scan     = (state_q == SCAN);
  assign frame_drop = fft_valid & ~in_ready;

  for (genvar g = 0; g < N_BINS; g++) begin : g_unpack
    assign w_bins[g] = buf_q[g*2*DW +: 2*DW];
  end

  assign w_bin = w_bins[idx_q];

  fft_mag_calc #(
    .DW (DW),
    .MW (MW)
  ) u_mag (
    .re_i   (w_bin[2*DW-1:DW]),
    .im_i   (w_bin[DW-1:0]),
    .mode_i (mode_q),
    .mag_o  (w_mag)
  );

  // Strictly-greater keeps the lowest index on ties; bin 0 is ignored when
  // DC skipping is enabled.
  assign w_better       = w_scan && !(skip_q && (idx_q == '0)) && (w_mag > best_mag_q);
  assign w_best_mag_nxt = w_better ? w_mag : best_mag_q;
  assign w_best_idx_nxt = w_better ? idx_q : best_idx_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_q        <= '0;
      mode_q       <= 1'b0;
      skip_q       <= 1'b0;
      thresh_q     <= '0;
      idx_q        <= '0;
      best_mag_q   <= '0;
      best_idx_q   <= '0;
      freq_q       <= '0;
      peak_mag_q   <= '0;
      peak_valid_q <= 1'b0;
    end else if (w_capture) begin
      buf_q      <= fft_data;
      mode_q     <= mode;
      skip_q     <= skip_dc;
      thresh_q   <= thresh;
      idx_q      <= '0;
      best_mag_q <= '0;
      // With DC skipped, an all-zero frame must still report a non-DC bin.
      best_idx_q <= skip_dc ? IDX_W'(1) : '0;
    end else if (w_scan) begin
      best_mag_q <= w_best_mag_nxt;
      best_idx_q <= w_best_idx_nxt;
      if (idx_q == LAST_IDX) begin
        // Results include the final bin's comparison and appear with done.
        freq_q       <= w_best_idx_nxt;
        peak_mag_q   <= w_best_mag_nxt;
        peak_valid_q <= (w_best_mag_nxt > thresh_q);
      end else begin
        idx_q <= idx_q + IDX_W'(1);
      end
    end
  end

  assign freq       = freq_q;
  assign peak_mag   = peak_mag_q;
  assign peak_valid = peak_valid_q;

endmodule
`default_nettype wire

// File: doc/fft_peak_scan.md
Name: fft_peak_scan

Overview:
- Parametrised successor of the FFT peak-frequency analyser; sits after the FFT core.
- Captures one frame of N_BINS complex bins on a valid/ready handshake and scans it one bin per clock.
- Reports the index and magnitude of the strongest bin, plus a threshold-qualified detection flag.
- Adds exact (non-truncated) magnitude arithmetic, a selectable magnitude mode, DC-bin skipping, back-to-back frames and dropped-frame reporting.

Parameters:
- N_BINS, 16, number of complex bins per frame; power of two, at least 2.
- DW, 16, width of each signed real/imag component.
- Derived localparam IDX_W = $clog2(N_BINS).
- Derived localparam MW = 2*DW+1, width of the magnitude result.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- fft_valid  in  1  frame present on fft_data.
- in_ready  out  1  block can accept a frame this cycle.
- fft_data  in  N_BINS*2*DW  packed bins; bin i at [i*2*DW +: 2*DW]; real in the upper DW bits, imag in the lower DW bits; two's complement.
- mode  in  1  0 = re²+im², 1 = |re|+|im|; sampled at capture.
- skip_dc  in  1  1 = exclude bin 0 from the search; sampled at capture.
- thresh  in  MW  detection threshold; sampled at capture.
- done  out  1  one-cycle pulse; results below are updated in the same cycle.
- freq  out  IDX_W  index of the peak bin.
- peak_mag  out  MW  magnitude of the peak bin, unsigned.
- peak_valid  out  1  peak_mag > thresh (strictly greater).
- frame_drop  out  1  one-cycle pulse when a frame is offered and not accepted.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; all registered outputs 0.
  - Frame buffer, scan index and best-so-far registers cleared.
  - in_ready=1 in the first cycle after rst releases.
- Reset asserted mid-scan aborts the frame; no done is produced for it.
- States:
  - IDLE: in_ready=1. fft_valid sampled high → buffer loaded, mode/skip_dc/thresh latched, scan index=0, best_mag=0, best_idx=0 → SCAN.
  - SCAN: in_ready=0. Each cycle: magnitude of buf[idx] computed combinationally and compared with best_mag; best is updated only on strictly greater (ties keep the lower index). Bin 0 is not compared when skip_dc=1. idx increments each cycle; after idx=N_BINS-1 is compared → DONE.
  - DONE: done=1 for exactly one cycle; freq, peak_mag and peak_valid are registered from best_* and held until the next done. in_ready=1. fft_valid high → capture next frame → SCAN; otherwise → IDLE.
- Latency: capture at edge k, done high during cycle k+N_BINS+1. Throughput is one frame per N_BINS+1 cycles.
- fft_valid high while in_ready=0 → frame_drop pulses that cycle. The in-flight scan and held results are unaffected.
- Arithmetic:
  - Mode 0: re*re + im*im in full precision, unsigned MW bits; the maximum, 2^(2*DW-1) at re=im=-2^(DW-1), fits.
  - Mode 1: |re|+|im| in DW+1 bits, zero-extended to MW; |-2^(DW-1)| is represented exactly.
  - No truncation and no +1 bias on negative values.
- All-zero frame → freq=0, or 1 when skip_dc=1 (best_idx initialised to 1 in that case); peak_mag=0, peak_valid=0 when thresh≥0.
- Index counter does not wrap: the exit decision is taken at N_BINS-1.

Decomposition:
- Shared package: mode encodings (MAG_POW=0, MAG_L1=1) and the state encoding (IDLE, SCAN, DONE).
- Sub-module fft_mag_calc: combinational; DW-bit re/im plus mode in → MW-bit unsigned magnitude. Reused by later spectral blocks.
- Top level holds the buffer, FSM, index counter and best-so-far registers.

Test Plan (N_BINS=16, DW=16):
1. Bin 5 = (100,0), all others 0, mode 0, thresh 0, captured at edge k → done at k+17; freq=5, peak_mag=10000, peak_valid=1.
2. Bins 3 and 9 both (30,40), mode 0 → freq=3, peak_mag=2500. Repeat in mode 1 → freq=3, peak_mag=70.
3. Bin 7 = (-32768,-32768), mode 0 → peak_mag=2147483648, freq=7. Mode 1 → peak_mag=65536. Bin 0 = (500,0), bin 2 = (10,0), skip_dc=1 → freq=2, peak_mag=100.
4. All-zero frame, thresh 0 → freq=0, peak_mag=0, peak_valid=0. Bin 4 = (10,0), thresh 100 → peak_valid=0; thresh 99 → peak_valid=1.
5. fft_valid held high for 3 frames: frame A accepted; frame_drop pulses on every SCAN cycle; frame B accepted in A's DONE cycle; B's done follows 17 cycles after A's done; A's results stay held until then.
6. rst asserted at scan cycle 8 → all outputs 0 immediately, no done. After release, in_ready=1 and a new frame completes normally.
